// File: rtl/mem_lsu_port.sv
// mem_lsu_port: single-port data memory with valid/ready request/response handshake and programmable latency
module mem_lsu_port #(
  parameter int ADDR_W = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 2 ? $clog2(LATENCY - 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] off;
  logic [AW-1:0] idx;
  logic err, acc;
  logic [31:0] w, rd, wd;
  logic [3:0] be;
  assign off = req_addr - BASE_ADDR;
  assign idx = off[AW+1:2];
  // any offset bit above the word index means the access lies outside the array
  assign err = (req_size == 2'd3) | (req_size == 2'd1 & req_addr[0]) |
               (req_size == 2'd2 & |req_addr[1:0]) | (|off[ADDR_W-1:AW+2]);
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign acc = req_valid & req_ready;
  assign w = mem[idx] >> {req_addr[1:0], 3'b000};
  assign be = (req_size == 2'd0 ? 4'b0001 : req_size == 2'd1 ? 4'b0011 : 4'b1111) << req_addr[1:0];
  assign wd = req_wdata << {req_addr[1:0], 3'b000};
  always_comb
    rd = err ? 32'd0 :
         req_size == 2'd0 ? {{24{req_sext & w[7]}}, w[7:0]} :
         req_size == 2'd1 ? {{16{req_sext & w[15]}}, w[15:0]} : w;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (acc) begin
        state_n = LATENCY == 1 ? RESP : WAIT;
        cnt_n = CW'(LATENCY - 2);
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) state_n = RESP;
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (acc) begin
        resp_rdata <= req_wen ? 32'd0 : rd;
        resp_err <= err;
      end
    end
  // array has no reset so an accepted store survives a later reset
  always_ff @(posedge clk)
    if (acc & req_wen & ~err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i+:8] <= wd[8*i+:8];
endmodule

// File: tb/tb_mem_lsu_port.sv
// tb_mem_lsu_port: randomized and directed checks of mem_lsu_port against a byte-level reference model
module tb_mem_lsu_port;
  localparam int L = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_wen = 0, req_sext = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0] mb [4096];
  int total = 0, bad = 0;

  mem_lsu_port #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic wen, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic e);
    logic [31:0] off;
    int n;
    off = addr - BASE;
    n = 1 << size;
    e = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) || off >= 32'd4096;
    rd = 0;
    if (!e)
      for (int i = 0; i < n; i++)
        if (wen) mb[off+i] = wdata[8*i+:8];
        else rd |= 32'(mb[off+i]) << (8 * i);
    if (!e && !wen && sext && n < 4 && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8 * n);
  endtask

  task automatic xact(input logic wen, input logic [1:0] size, input logic sext,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] er;
    logic ee;
    int lat;
    model(wen, size, sext, addr, wdata, er, ee);
    check("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_wen = wen; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, L);
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", 32'(resp_valid), 1);
      check("bp_ready", 32'(req_ready), 0);
      check("bp_rdata", resp_rdata, er);
      check("bp_err", 32'(resp_err), 32'(ee));
      req_valid = 1; req_wen = 1; req_size = 2; req_addr = BASE + 60; req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 0;
    check("rdata", resp_rdata, er);
    check("err", 32'(resp_err), 32'(ee));
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("resp_drop", 32'(resp_valid), 0);
  endtask

  initial begin
    logic [31:0] a, d, er;
    logic [1:0] s;
    logic ee;
    #1;
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", 32'(resp_err), 0);
    @(negedge clk);
    rst = 0;
    #1 check("rst_ready", 32'(req_ready), 1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) xact(1, 2, 0, BASE + 32'(4 * i), $urandom, 0);
    xact(1, 2, 0, BASE, 32'hDEAD_BEEF, 0);
    xact(0, 2, 0, BASE, 0, 0);
    xact(1, 0, 0, BASE + 3, 32'h80, 0);
    xact(0, 0, 1, BASE + 3, 0, 0);
    xact(0, 0, 0, BASE + 3, 0, 0);
    xact(1, 2, 0, BASE, 32'h80EF_0000, 0);
    xact(0, 1, 1, BASE + 2, 0, 0);
    xact(1, 2, 0, BASE + 4, 32'h1122_3344, 0);
    xact(1, 1, 0, BASE + 6, 32'h0000_AABB, 0);
    xact(0, 2, 0, BASE + 4, 0, 0);
    xact(0, 1, 1, BASE + 1, 0, 0);
    xact(0, 2, 0, BASE + 2, 0, 0);
    xact(0, 3, 0, BASE + 8, 0, 0);
    xact(1, 3, 0, BASE + 8, 32'h5555_5555, 0);
    xact(0, 2, 0, BASE + 4096, 0, 0);
    xact(1, 2, 0, 32'h7FFF_FFFC, 32'hCAFE_F00D, 0);
    xact(1, 2, 0, BASE + 5, 32'hCAFE_F00D, 0);
    xact(0, 2, 0, BASE + 4, 0, 0);
    xact(0, 2, 0, BASE + 8, 0, 0);
    xact(0, 2, 0, BASE + 60, 0, 5);
    xact(0, 2, 0, BASE + 60, 0, 0);
    model(1, 2, 0, BASE + 12, 32'h1357_9BDF, er, ee);
    req_valid = 1; req_wen = 1; req_size = 2; req_addr = BASE + 12; req_wdata = 32'h1357_9BDF;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("midrst_valid", 32'(resp_valid), 0);
    check("midrst_rdata", resp_rdata, 0);
    @(negedge clk);
    rst = 0;
    #1 check("midrst_ready", 32'(req_ready), 1);
    @(negedge clk);
    xact(0, 2, 0, BASE + 12, 0, 0);
    for (int i = 0; i < 80; i++) begin
      s = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      a = BASE + $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1) ? BASE + 4096 + $urandom_range(0, 255) : BASE - 4 * $urandom_range(1, 8);
      d = $urandom;
      xact(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 2));
    end
    for (int i = 0; i < 16; i++) xact(0, 2, 0, BASE + 32'(4 * i), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
